config_chain_loader: RTL



---
 rtl/config_chain_loader_if.sv | 21 ++
 rtl/config_chain_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader_if.sv
// Word stream into the configuration chain loader: valid/ready handshake
// carrying one bitstream word per transfer.
interface config_chain_loader_if #(
    parameter int WORD_WIDTH = 8
);
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/config_chain_loader.sv
// Serialises bitstream words LSB-first onto a fabric configuration chain and
// stops after exactly CHAIN_LENGTH bits. Define CONFIG_CHAIN_LOADER_CRC_EN to add
// a CRC-16-CCITT of the shifted bits on output crc.
module config_chain_loader #(
    parameter int WORD_WIDTH   = 8,
    parameter int CHAIN_LENGTH = 1000,
    parameter int COUNT_WIDTH  = 16,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    config_chain_loader_if.slave   in_s,
    output logic                   cfg_data,
    output logic                   cfg_enable,
    output logic                   cfg_nreset,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] bits_loaded
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    ,
    output logic [15:0]            crc
`endif
);

    localparam int BW = $clog2(WORD_WIDTH + 1);
    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [COUNT_WIDTH-1:0] CHAIN_LEN_C = COUNT_WIDTH'(CHAIN_LENGTH);
    localparam logic [CW-1:0]          CLEAR_LAST  = CW'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    logic                   cfg_data_q, cfg_data_d;
    logic                   cfg_enable_q, cfg_enable_d;
    logic                   cfg_nreset_q, cfg_nreset_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [COUNT_WIDTH-1:0] bits_q, bits_d;
    logic [WORD_WIDTH-1:0]  shreg_q, shreg_d;
    logic [BW-1:0]          rem_q, rem_d;
    logic [CW-1:0]          clr_q, clr_d;

    // Bits to take from the next word: a full word, or whatever remains of the chain.
    function automatic logic [BW-1:0] word_bits(input logic [COUNT_WIDTH-1:0] loaded);
        logic [COUNT_WIDTH-1:0] left;
        left = CHAIN_LEN_C - loaded;
        if (left >= COUNT_WIDTH'(WORD_WIDTH)) begin
            return BW'(WORD_WIDTH);
        end
        return BW'(left);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            cfg_data_q   <= 1'b0;
            cfg_enable_q <= 1'b0;
            cfg_nreset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bits_q       <= '0;
            shreg_q      <= '0;
            rem_q        <= '0;
            clr_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            cfg_data_q   <= cfg_data_d;
            cfg_enable_q <= cfg_enable_d;
            cfg_nreset_q <= cfg_nreset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            bits_q       <= bits_d;
            shreg_q      <= shreg_d;
            rem_q        <= rem_d;
            clr_q        <= clr_d;
        end
    end

    // Outputs are registered, so each branch sets the values for the cycle it enters.
    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        cfg_data_d   = 1'b0;
        cfg_enable_d = 1'b0;
        cfg_nreset_d = cfg_nreset_q;
        busy_d       = busy_q;
        done_d       = done_q;
        bits_d       = cfg_enable_q ? bits_q + COUNT_WIDTH'(1) : bits_q;
        shreg_d      = shreg_q;
        rem_d        = rem_q;
        clr_d        = clr_q;

        case (state_q)
            IDLE, DONE: begin
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
                if (start) begin
                    state_d      = CLEAR;
                    cfg_nreset_d = 1'b0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    bits_d       = '0;
                    clr_d        = '0;
                    rem_d        = '0;
                end
            end

            CLEAR: begin
                if (clr_q == CLEAR_LAST) begin
                    state_d      = LOAD;
                    cfg_nreset_d = 1'b1;
                    in_ready_d   = 1'b1;
                end else begin
                    clr_d = clr_q + CW'(1);
                end
            end

            LOAD: begin
                if (in_s.in_valid && in_ready_q) begin
                    state_d      = SHIFT;
                    in_ready_d   = 1'b0;
                    cfg_enable_d = 1'b1;
                    cfg_data_d   = in_s.in_data[0];
                    shreg_d      = in_s.in_data >> 1;
                    rem_d        = word_bits(bits_q) - BW'(1);
                end
            end

            SHIFT: begin
                if (rem_q != '0) begin
                    cfg_enable_d = 1'b1;
                    cfg_data_d   = shreg_q[0];
                    shreg_d      = shreg_q >> 1;
                    rem_d        = rem_q - BW'(1);
                end else if (bits_q + COUNT_WIDTH'(1) == CHAIN_LEN_C) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    shreg_d = '0;
                end else begin
                    state_d    = LOAD;
                    in_ready_d = 1'b1;
                end
            end

            default: begin
                state_d      = IDLE;
                in_ready_d   = 1'b0;
                cfg_nreset_d = 1'b1;
                busy_d       = 1'b0;
            end
        endcase
    end

`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic        crc_fb;
    logic        enter_clear;

    assign enter_clear = start && ((state_q == IDLE) || (state_q == DONE));
    assign crc_fb      = crc_q[15] ^ cfg_data_q;

    // Bit-serial CCITT update on exactly the bits the chain sees.
    always_comb begin
        crc_d = crc_q;
        if (enter_clear) begin
            crc_d = 16'hFFFF;
        end else if (cfg_enable_q) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            crc_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;
`endif

    assign in_s.in_ready = in_ready_q;
    assign cfg_data      = cfg_data_q;
    assign cfg_enable    = cfg_enable_q;
    assign cfg_nreset    = cfg_nreset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign bits_loaded   = bits_q;

endmodule
